// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and
// bubble insertion. out_data, out_valid and in_ready come straight from flops.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] BUBBLE   = {DATA_W{1'b0}},
  parameter int unsigned       STICKY_W = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [STICKY_W-1:0] in_sticky,
  output logic                in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  input  logic                out_ready,
  output logic [STICKY_W-1:0] sticky_q,
  output logic [1:0]          occupancy
);

  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                s_valid_q, s_valid_d;
  logic [DATA_W-1:0]   s_data_q, s_data_d;
  logic [STICKY_W-1:0] sticky_d;
  logic                accept, pop;

  assign in_ready  = ~s_valid_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

  assign accept = in_valid & ~s_valid_q & ~flush;
  assign pop    = m_valid_q & out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    sticky_d  = accept ? in_sticky : sticky_q;
    if (flush) begin
      // A concurrent pop is still delivered: downstream samples out_data this cycle.
      m_valid_d = 1'b0;
      m_data_d  = BUBBLE;
      s_valid_d = 1'b0;
    end else if (!m_valid_q) begin
      if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
      end
    end else if (!s_valid_q) begin
      if (pop) begin
        m_valid_d = accept;
        m_data_d  = accept ? in_data : BUBBLE;
      end else if (accept) begin
        s_valid_d = 1'b1;
        s_data_d  = in_data;
      end
    end else if (pop) begin
      m_data_d  = s_data_q;
      s_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      m_valid_q <= 1'b0;
      m_data_q  <= BUBBLE;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      sticky_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      sticky_q  <= sticky_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed sequences plus a short random run, with accepted
// words queued by the driver and popped/compared by a separate output monitor.
module tb_pipe_stage_skid;
  localparam int unsigned DW  = 32;
  localparam logic [31:0] BUB = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [0:0]    in_sticky, sticky_q;
  logic [1:0]    occupancy;

  pipe_stage_skid #(.DATA_W(DW), .BUBBLE(BUB), .STICKY_W(1)) dut (
    .CLK(clk), .RST(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_sticky(in_sticky), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .sticky_q(sticky_q),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          armed  = 1'b0;
  logic [31:0] exp_q[$];
  int          mcnt    = 0;
  logic        msticky = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sample mid-cycle, the values the next posedge will see.
  always @(negedge clk) begin
    if (armed) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h, expected no word", out_data);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end else if (out_valid !== 1'b1) begin
        chk("bubble", out_data, BUB);
      end
    end
  end

  // One cycle: drive inputs, check current state against the model, clock, update model.
  task automatic step(input logic r, input logic f, input logic iv, input logic [31:0] d,
                      input logic st, input logic ordy);
    logic acc, popm;
    rst = r; flush = f; in_valid = iv; in_data = d; in_sticky = st; out_ready = ordy;
    if (armed) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, mcnt < 2});
      chk("out_valid", {31'b0, out_valid}, {31'b0, mcnt > 0});
      chk("occupancy", {30'b0, occupancy}, mcnt);
      chk("sticky_q", {31'b0, sticky_q}, {31'b0, msticky});
    end
    acc  = r & iv & (mcnt < 2) & ~f;
    popm = (mcnt > 0) & ordy;
    @(posedge clk);
    #1;
    if (!r) begin
      mcnt = 0; msticky = 1'b0; exp_q.delete();
    end else if (f) begin
      mcnt = 0; exp_q.delete();
    end else begin
      mcnt = mcnt - int'(popm) + int'(acc);
      if (acc) begin
        exp_q.push_back(d);
        msticky = st;
      end
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, ordy);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_sticky = '0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    // Reset for two cycles
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    armed = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("reset_data", out_data, BUB);
    chk("reset_ready", {31'b0, in_ready}, 32'd1);

    // Back-to-back stream
    step(1'b1, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1);
    chk("latency", out_data, 32'h11);
    step(1'b1, 1'b0, 1'b1, 32'h22, 1'b0, 1'b1);
    chk("stream2", out_data, 32'h22);
    step(1'b1, 1'b0, 1'b1, 32'h33, 1'b0, 1'b1);
    chk("stream3", out_data, 32'h33);
    idle(2, 1'b1);
    chk("after_stream", out_data, BUB);

    // Backpressure: two absorbed, third held upstream
    step(1'b1, 1'b0, 1'b1, 32'hA1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hA2, 1'b0, 1'b0);
    chk("bp_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_occ", {30'b0, occupancy}, 32'd2);
    step(1'b1, 1'b0, 1'b1, 32'hA3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hA3, 1'b0, 1'b1);
    chk("bp_recover", {31'b0, in_ready}, 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'hA3, 1'b0, 1'b1);
    chk("bp_a3", out_data, 32'hA3);
    idle(2, 1'b1);

    // Flush when full with an incoming word; sticky from C2 must survive
    step(1'b1, 1'b0, 1'b1, 32'hC1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hC2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'hB0, 1'b0, 1'b0);
    chk("flush_occ", {30'b0, occupancy}, 32'd0);
    chk("flush_data", out_data, BUB);
    chk("flush_sticky", {31'b0, sticky_q}, 32'd1);
    idle(2, 1'b1);

    // Sticky survives idle and flush, then follows the next accept
    step(1'b1, 1'b0, 1'b1, 32'h1, 1'b1, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("sticky_hold", {31'b0, sticky_q}, 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'h2, 1'b0, 1'b1);
    chk("sticky_clear", {31'b0, sticky_q}, 32'd0);
    idle(2, 1'b1);

    // Flush together with pop: D1 delivered, D2 discarded
    step(1'b1, 1'b0, 1'b1, 32'hD1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hD2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Mid-operation reset at occupancy 2
    step(1'b1, 1'b0, 1'b1, 32'hE1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hE2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hE3, 1'b1, 1'b1);
    chk("mid_rst_data", out_data, BUB);
    chk("mid_rst_sticky", {31'b0, sticky_q}, 32'd0);
    chk("mid_rst_occ", {30'b0, occupancy}, 32'd0);
    idle(3, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'b1, ($urandom_range(15) == 0), 1'($urandom_range(1)), $urandom,
           1'($urandom_range(1)), ($urandom_range(3) != 0));
    end
    idle(4, 1'b1);
    chk("drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
